// File: rtl/md_sched.sv
// Multiply/divide sequencer and HI/LO owner: computes mult/div results up front,
// then holds them back for the modelled unit latency while requesting ID stalls.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_is_md,
  output logic        start,
  output logic        busy,
  output logic [31:0] E_md_out,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi, pend_lo;
  logic [31:0]      pend_hi_nxt, pend_lo_nxt;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo_s, rem_s;
  logic        is_div;

  // Signed division is done on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // without relying on the behaviour of an overflowing signed divide.
  always_comb begin
    prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    prod_u = {32'd0, E_A} * {32'd0, E_B};
    a_mag  = E_A[31] ? (~E_A + 32'd1) : E_A;
    b_mag  = E_B[31] ? (~E_B + 32'd1) : E_B;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    quo_s  = (E_A[31] ^ E_B[31]) ? (~q_mag + 32'd1) : q_mag;
    rem_s  = E_A[31] ? (~r_mag + 32'd1) : r_mag;
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pend_hi_nxt = HI;
    pend_lo_nxt = LO;
    case (E_op)
      OP_MULT:  {pend_hi_nxt, pend_lo_nxt} = prod_s;
      OP_MULTU: {pend_hi_nxt, pend_lo_nxt} = prod_u;
      OP_DIV: begin
        if (E_B != 32'd0) begin
          pend_hi_nxt = rem_s;
          pend_lo_nxt = quo_s;
        end
      end
      OP_DIVU: begin
        if (E_B != 32'd0) begin
          pend_hi_nxt = E_A % E_B;
          pend_lo_nxt = E_A / E_B;
        end
      end
      default: ;
    endcase
  end

  assign is_div   = (E_op == OP_DIV) || (E_op == OP_DIVU);
  assign start    = (state == IDLE) && (E_op >= OP_MULT) && (E_op <= OP_DIVU);
  assign md_stall = D_is_md & (start | busy);

  always_comb begin
    E_md_out = 32'd0;
    if (E_op == OP_MFHI)      E_md_out = HI;
    else if (E_op == OP_MFLO) E_md_out = LO;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and
  // overrides an op in flight, so HI/LO read zero the cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            cnt     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy    <= 1'b1;
            state   <= RUN;
          end else if (E_op == OP_MTHI) begin
            HI <= E_A;
          end else if (E_op == OP_MTLO) begin
            LO <= E_A;
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            HI    <= pend_hi;
            LO    <= pend_lo;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed vector table, hand-written reset/busy sequences,
// and random ops checked against an arithmetic reference model.
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  E_op;
  logic [31:0] E_A, E_B;
  logic        D_is_md;
  logic        start, busy, md_stall;
  logic [31:0] E_md_out, HI, LO;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_op(E_op), .E_A(E_A), .E_B(E_B), .D_is_md(D_is_md),
    .start(start), .busy(busy), .E_md_out(E_md_out), .md_stall(md_stall), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        dmd;
    logic [31:0] hi, lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: results straight from 64-bit arithmetic, HI/LO kept on divide by zero.
  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] nhi, output logic [31:0] nlo);
    longint          sa, sb, q, r;
    longint unsigned p;
    nhi = hi_m;
    nlo = lo_m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin q = sa * sb; nhi = q[63:32]; nlo = q[31:0]; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; nhi = p[63:32]; nlo = p[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; nhi = r[31:0]; nlo = q[31:0]; end
      4'd4: if (b != 0) begin nhi = a % b; nlo = a / b; end
      4'd5: nhi = a;
      4'd6: nlo = a;
      default: ;
    endcase
  endtask

  // Presents one op in E for one cycle, then waits out any busy period.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic        arith;
    int          n, exp_n;
    logic [31:0] exp_out;
    arith   = (op >= 4'd1) && (op <= 4'd4);
    exp_n   = (op == 4'd3 || op == 4'd4) ? 10 : 5;
    exp_out = (op == 4'd7) ? hi_m : (op == 4'd8) ? lo_m : 32'd0;
    E_op = op; E_A = a; E_B = b; D_is_md = dmd;
    #1;
    check("start", {31'd0, start}, {31'd0, arith});
    check("md_stall_start", {31'd0, md_stall}, {31'd0, dmd & arith});
    check("E_md_out", E_md_out, exp_out);
    step();
    E_op = 4'd0;
    #1;
    if (arith) begin
      n = 0;
      while (busy && n < 200) begin
        check("md_stall_busy", {31'd0, md_stall}, {31'd0, dmd});
        step();
        n++;
      end
      check("busy_cycles", n, exp_n);
      check("md_stall_after", {31'd0, md_stall}, 32'd0);
    end else begin
      check("busy_idle", {31'd0, busy}, 32'd0);
    end
    check("HI", HI, exp_hi);
    check("LO", LO, exp_lo);
    hi_m = exp_hi;
    lo_m = exp_lo;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b, nhi, nlo;

    vecs[0] = '{4'd1, 32'hFFFF_FFFD, 32'd5,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'd2,        1'b0, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[3] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{4'd5, 32'h1234,      32'd0,        1'b0, 32'h0000_1234, 32'h8000_0000};
    vecs[5] = '{4'd6, 32'h5678,      32'd0,        1'b0, 32'h0000_1234, 32'h0000_5678};
    vecs[6] = '{4'd4, 32'd9,         32'd0,        1'b0, 32'h0000_1234, 32'h0000_5678};
    vecs[7] = '{4'd3, 32'd100,       32'd7,        1'b1, 32'h0000_0002, 32'h0000_000E};
    vecs[8] = '{4'd7, 32'd0,         32'd0,        1'b1, 32'h0000_0002, 32'h0000_000E};
    vecs[9] = '{4'd8, 32'd0,         32'd0,        1'b0, 32'h0000_0002, 32'h0000_000E};

    reset = 1'b1; E_op = 4'd0; E_A = 32'd0; E_B = 32'd0; D_is_md = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_HI", HI, 32'd0);
    check("rst_LO", LO, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dmd, vecs[i].hi, vecs[i].lo);

    // Ops reaching E while busy are ignored and reads still see the old HI/LO.
    E_op = 4'd1; E_A = 32'd3; E_B = 32'd4; D_is_md = 1'b0;
    step();
    E_op = 4'd5; E_A = 32'hDEAD;
    #1;
    check("busy_ignore_start", {31'd0, start}, 32'd0);
    step();
    E_op = 4'd3; E_A = 32'd50; E_B = 32'd5;
    #1;
    check("busy_ignore_div", {31'd0, start}, 32'd0);
    step();
    E_op = 4'd8;
    #1;
    check("busy_mflo_old", E_md_out, lo_m);
    step();
    E_op = 4'd0;
    for (int n = 0; n < 20 && busy; n++) step();
    check("ignore_HI", HI, 32'd0);
    check("ignore_LO", LO, 32'd12);
    hi_m = 32'd0; lo_m = 32'd12;

    // Reset on the third busy cycle abandons the multiply.
    E_op = 4'd1; E_A = 32'hFFFF_0000; E_B = 32'h1234;
    step();
    E_op = 4'd0;
    step();
    step();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_HI", HI, 32'd0);
    check("mid_rst_LO", LO, 32'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    run_op(4'd1, 32'd6, 32'd7, 1'b0, 32'd0, 32'd42);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      ref_op(op, a, b, nhi, nlo);
      run_op(op, a, b, 1'($urandom_range(0, 1)), nhi, nlo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
